// File: rtl/smg_decode_scanmod.sv
// Seven-segment readback monitor: decodes a scanned common-anode bus into a hex frame.
// Latency: digit captured STABLE+2 edges after its pattern appears; oDone one edge after the last capture.
// Backpressure: none; passive tap, frames are published whenever the capture mask fills.
module smg_decode_scanmod #(
  parameter int NDIG   = 6,
  parameter int STABLE = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [7:0]        iSeg,
  input  logic [NDIG-1:0]   iCol,
  output logic [4*NDIG-1:0] oData,
  output logic [NDIG-1:0]   oDp,
  output logic [NDIG-1:0]   oErr,
  output logic              oDone
);

  localparam int         DW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] CNT_MAX = 8'(STABLE);
  localparam logic [7:0] CNT_CAP = 8'(STABLE - 1);

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  logic [7:0]          r_seg1, r_seg2;
  logic [NDIG-1:0]     r_col1, r_col2;
  logic [7:0]          r_cnt;
  logic [NDIG-1:0]     r_mask;
  logic [4*NDIG-1:0]   r_wdata;
  logic [NDIG-1:0]     r_wdp;
  logic [NDIG-1:0]     r_werr;

  logic                w_same;
  logic                w_col_ok;
  logic [3:0]          w_nzero;
  logic [DW-1:0]       w_dig;
  logic [3:0]          w_nib;
  logic                w_bad;
  logic                w_cap;
  logic                w_full;

  assign w_same   = (r_seg1 == r_seg2) && (r_col1 == r_col2);
  assign w_col_ok = (w_nzero == 4'd1);
  assign w_cap    = (r_state == ST_ARMED) && (r_cnt == CNT_CAP) && w_same && w_col_ok;
  assign w_full   = &r_mask;

  // Count low select bits and locate the selected digit.
  always_comb begin
    w_nzero = '0;
    w_dig   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_col1[i]) begin
        w_nzero = w_nzero + 4'd1;
        w_dig   = DW'(i);
      end
    end
  end

  // Map the active-low a..g pattern back to its nibble; anything else is illegal.
  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (r_seg1[6:0])
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_bad = 1'b1;
      end
    endcase
  end

  // Two-deep sample pipeline so successive bus samples can be compared.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_seg1 <= '0;
      r_col1 <= '0;
      r_seg2 <= '0;
      r_col2 <= '0;
    end else begin
      r_seg1 <= iSeg;
      r_col1 <= iCol;
      r_seg2 <= r_seg1;
      r_col2 <= r_col1;
    end
  end

  // Stability counter: restarts on any change or bad select, saturates so it never wraps.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (!w_same || !w_col_ok) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Arm/hold FSM, per-digit capture and frame publication share the mask.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state <= ST_ARMED;
      r_mask  <= '0;
      r_wdata <= '0;
      r_wdp   <= '0;
      r_werr  <= '0;
      oData   <= '0;
      oDp     <= '0;
      oErr    <= '0;
      oDone   <= 1'b0;
    end else begin
      oDone <= w_full;
      // Publish the completed frame; a capture on this same edge starts the next one.
      if (w_full) begin
        oData  <= r_wdata;
        oDp    <= r_wdp;
        oErr   <= r_werr;
        r_mask <= '0;
      end
      case (r_state)
        ST_ARMED: begin
          if (w_cap) begin
            r_wdata[4*w_dig +: 4] <= w_nib;
            r_wdp[w_dig]          <= ~r_seg1[7];
            r_werr[w_dig]         <= w_bad;
            r_mask[w_dig]         <= 1'b1;
            r_state               <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Wait for the dwell to end so it is captured only once.
          if (!w_same || !w_col_ok) r_state <= ST_ARMED;
        end
        default: r_state <= ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_smg_decode_scanmod.sv
// Bench for smg_decode_scanmod: directed scan frames plus random dwell sequences.
// Reference model works per dwell: a valid-select dwell lasting at least STABLE+2
// cycles lands in the frame on its (STABLE+2)th edge; the frame publishes one edge after the mask fills.
module tb_smg_decode_scanmod;

  localparam int NDIG   = 6;
  localparam int STABLE = 4;
  localparam int CAP_E  = STABLE + 2;

  logic              CLOCK;
  logic              RESET;
  logic [7:0]        iSeg;
  logic [NDIG-1:0]   iCol;
  logic [4*NDIG-1:0] oData;
  logic [NDIG-1:0]   oDp;
  logic [NDIG-1:0]   oErr;
  logic              oDone;

  smg_decode_scanmod #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iSeg  (iSeg),
    .iCol  (iCol),
    .oData (oData),
    .oDp   (oDp),
    .oErr  (oErr),
    .oDone (oDone)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Active-low a..g patterns for hex digits 0..F.
  logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_tests;
  int n_fail;
  int n_done;
  int done_at;

  // Reference model state.
  logic [3:0]        m_wd [NDIG];
  logic [NDIG-1:0]   m_wdp, m_werr, m_mask;
  logic [4*NDIG-1:0] m_od;
  logic [NDIG-1:0]   m_odp, m_oerr;
  logic              m_done;
  logic [13:0]       prev_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDIG; k++) m_wd[k] = 4'h0;
    m_wdp  = '0;
    m_werr = '0;
    m_mask = '0;
    m_od   = '0;
    m_odp  = '0;
    m_oerr = '0;
    m_done = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_done"}, 32'(oDone), 32'(m_done));
    chk({tag, "_data"}, 32'(oData), 32'(m_od));
    chk({tag, "_dp"},   32'(oDp),   32'(m_odp));
    chk({tag, "_err"},  32'(oErr),  32'(m_oerr));
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      RESET = 1'b0;
      iSeg  = 8'($urandom);
      iCol  = 6'($urandom);
      @(posedge CLOCK);
      model_clear();
      @(negedge CLOCK);
      check_outputs("reset");
    end
    RESET    = 1'b1;
    prev_pat = '0;
  endtask

  // Hold one bus pattern for d cycles, advancing the model edge by edge.
  task automatic run_dwell(input logic [7:0] seg, input logic [NDIG-1:0] col, input int d);
    bit         valid;
    int         dig;
    logic [3:0] nib;
    bit         bad;
    iSeg  = seg;
    iCol  = col;
    valid = ($countones(~col) == 1);
    dig   = 0;
    for (int k = 0; k < NDIG; k++) if (!col[k]) dig = k;
    nib = 4'h0;
    bad = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (SEGTAB[k] == seg[6:0]) begin
        nib = 4'(k);
        bad = 1'b0;
      end
    end
    done_at = 0;
    for (int e = 1; e <= d; e++) begin
      @(posedge CLOCK);
      if (m_mask == '1) begin
        for (int k = 0; k < NDIG; k++) m_od[4*k +: 4] = m_wd[k];
        m_odp  = m_wdp;
        m_oerr = m_werr;
        m_done = 1'b1;
        m_mask = '0;
      end else begin
        m_done = 1'b0;
      end
      if (valid && e == CAP_E) begin
        m_wd[dig]   = nib;
        m_wdp[dig]  = ~seg[7];
        m_werr[dig] = bad;
        m_mask[dig] = 1'b1;
      end
      @(negedge CLOCK);
      check_outputs("edge");
      if (oDone === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = e;
      end
    end
    prev_pat = {seg, col};
  endtask

  function automatic logic [NDIG-1:0] sel(input int d);
    logic [NDIG-1:0] one;
    one = 6'b000001;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] dig_seg(input int v);
    return {1'b1, SEGTAB[v]};
  endfunction

  initial begin
    int              d0;
    logic [7:0]      rs;
    logic [NDIG-1:0] rc;
    int              rd;

    n_tests  = 0;
    n_fail   = 0;
    n_done   = 0;
    RESET    = 1'b0;
    iSeg     = '0;
    iCol     = '1;
    prev_pat = '0;
    model_clear();

    // Reset with random bus activity.
    do_reset(3);

    // Full frame: digits 0..5 showing 0..5, 10-cycle dwells.
    d0 = n_done;
    for (int k = 0; k < NDIG; k++) run_dwell(dig_seg(k), sel(k), 10);
    chk("frame1_done_count", 32'(n_done - d0), 32'd1);
    chk("frame1_done_edge",  32'(done_at), 32'(CAP_E + 1));
    chk("frame1_data",       32'(oData), 32'h543210);
    chk("frame1_err",        32'(oErr),  32'h0);
    chk("frame1_dp",         32'(oDp),   32'h0);

    // Short dwell on digit 2 is ignored; a longer re-scan completes the frame.
    d0 = n_done;
    run_dwell(dig_seg(0), sel(0), 10);
    run_dwell(dig_seg(1), sel(1), 10);
    run_dwell(dig_seg(2), sel(2), 4);
    for (int k = 3; k < NDIG; k++) run_dwell(dig_seg(k), sel(k), 10);
    chk("short_no_done", 32'(n_done - d0), 32'd0);
    run_dwell(dig_seg(2), sel(2), 8);
    chk("short_rescan_done", 32'(n_done - d0), 32'd1);
    chk("short_rescan_data", 32'(oData), 32'h543210);

    // Blank digit with dp lit: nibble 0, error and dp flagged for digit 3.
    for (int k = 0; k < NDIG; k++) run_dwell((k == 3) ? 8'h7F : dig_seg(k), sel(k), 9);
    run_dwell(8'hFF, 6'b111111, 3);
    chk("illegal_data", 32'(oData), 32'h540210);
    chk("illegal_err",  32'(oErr),  32'b001000);
    chk("illegal_dp",   32'(oDp),   32'b001000);

    // Two selects low for 20 cycles never capture; a clean 6-cycle dwell does.
    d0 = n_done;
    run_dwell(dig_seg(7), 6'b111100, 20);
    run_dwell(8'h8E, 6'b111110, CAP_E);
    for (int k = 1; k < NDIG; k++) run_dwell(dig_seg(k), sel(k), 8);
    run_dwell(8'hFF, 6'b111111, 3);
    chk("badcol_done", 32'(n_done - d0), 32'd1);
    chk("badcol_data", 32'(oData), 32'h54321F);

    // Reset mid-frame discards partial work.
    for (int k = 0; k < 3; k++) run_dwell(dig_seg(9 - k), sel(k), 9);
    do_reset(1);
    chk("midreset_data", 32'(oData), 32'h0);
    d0 = n_done;
    for (int k = 0; k < NDIG - 1; k++) run_dwell(dig_seg(10 + k), sel(k), 9);
    chk("midreset_no_early_done", 32'(n_done - d0), 32'd0);
    run_dwell(dig_seg(15), sel(5), 9);
    chk("midreset_done", 32'(n_done - d0), 32'd1);
    chk("midreset_data_new", 32'(oData), 32'hFEDCBA);

    // Random dwells, selects, patterns and occasional resets.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 29) == 0) do_reset(1);
      do begin
        if ($urandom_range(0, 9) < 7) rc = sel($urandom_range(0, NDIG - 1));
        else                          rc = 6'($urandom);
        if ($urandom_range(0, 3) != 0) rs = {1'($urandom), SEGTAB[$urandom_range(0, 15)]};
        else                           rs = 8'($urandom);
      end while ({rs, rc} == prev_pat);
      rd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(CAP_E, 12));
      run_dwell(rs, rc, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
